// File: rtl/ecc_serial_host_if.sv
// ecc_serial_host_if
// Command and response handshake bundle of the ECC host endpoint.
//   master : system bus adapter side (drives the command, accepts the response)
//   slave  : ecc_serial_host side (accepts the command, drives the response)
// Signals:
//   cmd_valid/cmd_ready                             command handshake
//   cmd_a, cmd_prime, cmd_px, cmd_py, cmd_k [W]     parallel operands
//   rsp_valid/rsp_ready                             response handshake
//   rsp_x, rsp_y [W]                                assembled kPx / kPy
//   rsp_timeout                                     response is a timeout marker
interface ecc_serial_host_if #(
    parameter int NIBBLES = 8
);
    localparam int W = 4 * NIBBLES;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_prime;
    logic [W-1:0] cmd_px;
    logic [W-1:0] cmd_py;
    logic [W-1:0] cmd_k;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_x;
    logic [W-1:0] rsp_y;
    logic         rsp_timeout;

    modport master (
        output cmd_valid, cmd_a, cmd_prime, cmd_px, cmd_py, cmd_k, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_x, rsp_y, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_prime, cmd_px, cmd_py, cmd_k, rsp_ready,
        output cmd_ready, rsp_valid, rsp_x, rsp_y, rsp_timeout
    );
endinterface

// File: rtl/ecc_serial_host.sv
// ecc_serial_host
// Host-side endpoint of the ECC core's nibble-serial link. Accepts one
// scalar-multiplication command, shifts its operands to the core LSB nibble
// first behind a one-cycle o_start, waits for i_done, then reassembles the
// nibble-serial kPx/kPy result and offers it on the response handshake.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   bus (slave)        command/response handshake (ecc_serial_host_if)
//   o_start            frame start, coincident with nibble 0
//   o_a..o_k [4]       operand nibbles to the core
//   i_done             core completion pulse
//   i_kpx, i_kpy [4]   result nibbles from the core
// Parameters: NIBBLES (nibbles per word), TIMEOUT (WAIT cycle bound).
// Optional feature: define ECC_HOST_TIMEOUT_EN to bound WAIT by TIMEOUT
// cycles and answer with rsp_timeout=1; otherwise WAIT is unbounded and
// rsp_timeout is tied low.
module ecc_serial_host #(
    parameter int NIBBLES = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    ecc_serial_host_if.slave bus,
    output logic             o_start,
    output logic [3:0]       o_a,
    output logic [3:0]       o_prime,
    output logic [3:0]       o_px,
    output logic [3:0]       o_py,
    output logic [3:0]       o_k,
    input  logic             i_done,
    input  logic [3:0]       i_kpx,
    input  logic [3:0]       i_kpy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  lat_a, lat_prime, lat_px, lat_py, lat_k;

    assign cnt_nxt = cnt + 1'b1;

`ifdef ECC_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          expired;

    // Held at zero outside WAIT, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + 1'b1;
    end

    assign expired = (wait_cnt == TW'(TIMEOUT - 1));
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_x     <= '0;
            bus.rsp_y     <= '0;
`ifdef ECC_HOST_TIMEOUT_EN
            bus.rsp_timeout <= 1'b0;
`endif
            o_start       <= 1'b0;
            o_a           <= '0;
            o_prime       <= '0;
            o_px          <= '0;
            o_py          <= '0;
            o_k           <= '0;
            lat_a         <= '0;
            lat_prime     <= '0;
            lat_px        <= '0;
            lat_py        <= '0;
            lat_k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        lat_a         <= bus.cmd_a;
                        lat_prime     <= bus.cmd_prime;
                        lat_px        <= bus.cmd_px;
                        lat_py        <= bus.cmd_py;
                        lat_k         <= bus.cmd_k;
                        bus.cmd_ready <= 1'b0;
                        bus.rsp_x     <= '0;
                        bus.rsp_y     <= '0;
`ifdef ECC_HOST_TIMEOUT_EN
                        bus.rsp_timeout <= 1'b0;
`endif
                        cnt           <= '0;
                        // Nibble 0 comes straight from the command so it is
                        // on the link in the cycle right after acceptance.
                        o_start       <= 1'b1;
                        o_a           <= bus.cmd_a[3:0];
                        o_prime       <= bus.cmd_prime[3:0];
                        o_px          <= bus.cmd_px[3:0];
                        o_py          <= bus.cmd_py[3:0];
                        o_k           <= bus.cmd_k[3:0];
                        state         <= SEND;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                SEND: begin
                    o_start <= 1'b0;
                    if (cnt == LAST) begin
                        o_a     <= '0;
                        o_prime <= '0;
                        o_px    <= '0;
                        o_py    <= '0;
                        o_k     <= '0;
                        state   <= WAIT;
                    end else begin
                        cnt     <= cnt_nxt;
                        o_a     <= lat_a[{cnt_nxt, 2'b00} +: 4];
                        o_prime <= lat_prime[{cnt_nxt, 2'b00} +: 4];
                        o_px    <= lat_px[{cnt_nxt, 2'b00} +: 4];
                        o_py    <= lat_py[{cnt_nxt, 2'b00} +: 4];
                        o_k     <= lat_k[{cnt_nxt, 2'b00} +: 4];
                    end
                end
                WAIT: begin
                    // i_done has priority over an expiry in the same cycle.
                    if (i_done) begin
                        cnt   <= '0;
                        state <= RECV;
                    end
`ifdef ECC_HOST_TIMEOUT_EN
                    else if (expired) begin
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        state           <= RESP;
                    end
`endif
                end
                RECV: begin
                    bus.rsp_x[{cnt, 2'b00} +: 4] <= i_kpx;
                    bus.rsp_y[{cnt, 2'b00} +: 4] <= i_kpy;
                    if (cnt == LAST) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_serial_host.sv
// tb_ecc_serial_host
// Directed bench for ecc_serial_host: a timeline model (command accept,
// done and response edges plus arithmetic on the operand words) predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_ecc_serial_host;
    localparam int NIB = 8;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       o_start;
    logic [3:0] o_a, o_prime, o_px, o_py, o_k;
    logic       i_done = 1'b0;
    logic [3:0] i_kpx = '0;
    logic [3:0] i_kpy = '0;

    ecc_serial_host_if #(.NIBBLES(NIB)) bus ();

    ecc_serial_host #(.NIBBLES(NIB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .o_start(o_start), .o_a(o_a), .o_prime(o_prime), .o_px(o_px),
        .o_py(o_py), .o_k(o_k), .i_done(i_done), .i_kpx(i_kpx), .i_kpy(i_kpy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    int          cyc = 0;
    logic        m_ready = 1'b0;
    logic        m_active = 1'b0;
    int          t_acc = -1000;
    int          t_done = -1;
    int          t_resp = -1;
    logic [31:0] m_ops [5];
    logic [31:0] m_x = '0, m_y = '0;
    logic        m_to = 1'b0;
    logic [31:0] core_x = '0, core_y = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_ready = 1'b0; m_active = 1'b0; t_done = -1; t_resp = -1;
            m_x = '0; m_y = '0; m_to = 1'b0;
        end else if (!m_active) begin
            if (m_ready && bus.cmd_valid) begin
                m_active = 1'b1; m_ready = 1'b0; t_acc = cyc; t_done = -1; t_resp = -1;
                m_ops[0] = bus.cmd_a; m_ops[1] = bus.cmd_prime; m_ops[2] = bus.cmd_px;
                m_ops[3] = bus.cmd_py; m_ops[4] = bus.cmd_k;
                m_x = '0; m_y = '0; m_to = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end else if (t_resp >= 0) begin
            if (bus.rsp_ready) begin m_active = 1'b0; m_ready = 1'b1; end
        end else if (t_done >= 0) begin
            if (cyc == t_done + NIB) begin t_resp = cyc; m_x = core_x; m_y = core_y; end
        end else if (cyc > t_acc + NIB) begin
            if (i_done) t_done = cyc;
`ifdef ECC_HOST_TIMEOUT_EN
            else if (cyc == t_acc + NIB + TO) begin t_resp = cyc; m_to = 1'b1; end
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int          idx;
        logic [20:0] el;
        if (cyc > 0) begin
            el  = '0;
            idx = cyc - t_acc;
            if (m_active && t_done < 0 && t_resp < 0 && idx >= 0 && idx < NIB) begin
                el[20] = (idx == 0);
                for (int j = 0; j < 5; j++) el[4*(4-j) +: 4] = 4'(m_ops[j] >> (4*idx));
            end
            chk("link", {o_start, o_a, o_prime, o_px, o_py, o_k}, el);
            chk("cmd_ready", bus.cmd_ready, m_ready);
            chk("rsp_valid", bus.rsp_valid, m_active && t_resp >= 0);
            chk("rsp_timeout", bus.rsp_timeout, m_to);
            if (!(m_active && t_done >= 0 && t_resp < 0)) begin
                chk("rsp_x", bus.rsp_x, m_x);
                chk("rsp_y", bus.rsp_y, m_y);
            end
        end
    end

    // ---------------- observation monitor ----------------
    int          acc_cyc = 0, hs_cyc = 0, rise_cyc = 0, rv_cnt = 0;
    int          start_cnt = 0, px_cnt = 0, seq_i = NIB;
    logic        prev_rv = 1'b0;
    logic [31:0] obs_prime = '0;

    always @(negedge clk) begin
        #1;
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc + 1;
        if (bus.rsp_valid && bus.rsp_ready) hs_cyc = cyc + 1;
        if (bus.rsp_valid && !prev_rv) rise_cyc = cyc;
        prev_rv = bus.rsp_valid;
        if (bus.rsp_valid) rv_cnt++;
        if (o_start) begin start_cnt++; seq_i = 0; end
        if (seq_i < NIB) begin obs_prime[4*seq_i +: 4] = o_prime; seq_i++; end
        if (o_px != 4'h0) px_cnt++;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    logic [31:0] got_x, got_y;
    logic        got_to;

    task automatic send_cmd(input logic [31:0] a, p, x, y, k, input bit hold_valid);
        int n = 0;
        bus.cmd_a = a; bus.cmd_prime = p; bus.cmd_px = x; bus.cmd_py = y; bus.cmd_k = k;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_accept", bus.cmd_ready, 1'b1);
        @(negedge clk);
        if (!hold_valid) bus.cmd_valid = 1'b0;
    endtask

    task automatic do_core(input int lat, input logic [31:0] x, y);
        core_x = x; core_y = y;
        repeat (lat) @(negedge clk);
        i_done = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            i_done = 1'b0; i_kpx = x[4*i +: 4]; i_kpy = y[4*i +: 4];
        end
        @(negedge clk);
        i_kpx = '0; i_kpy = '0;
    endtask

    task automatic wait_resp(input int hold, input bit keep_ready);
        int n = 0;
        while (!bus.rsp_valid && n < 3000) begin @(negedge clk); n++; end
        chk("rsp_arrives", bus.rsp_valid, 1'b1);
        got_x = bus.rsp_x; got_y = bus.rsp_y; got_to = bus.rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
            chk("bp_valid", bus.rsp_valid, 1'b1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        if (!keep_ready) bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs1;
        int n;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_a = '0; bus.cmd_prime = '0; bus.cmd_px = '0; bus.cmd_py = '0; bus.cmd_k = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1'b0);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_link", {o_start, o_a, o_prime, o_px, o_py, o_k}, 21'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.cmd_ready, 1'b1);

        // Basic transfer
        start_cnt = 0;
        send_cmd(32'h2, 32'h11, 32'h5, 32'h1, 32'h2, 1'b0);
        do_core(8, 32'h12345678, 32'h09ABCDEF);
        wait_resp(0, 1'b0);
        chk("basic_start_pulses", start_cnt, 1);
        chk("basic_prime_seq", obs_prime, 32'h00000011);
        chk("basic_x", got_x, 32'h12345678);
        chk("basic_y", got_y, 32'h09ABCDEF);
        chk("basic_to", got_to, 1'b0);

        // Back-pressure
        send_cmd(32'hDEADBEEF, 32'hFFFFFFFB, 32'h0F1E2D3C, 32'h4B5A6978, 32'h80000001, 1'b0);
        do_core(12, 32'hCAFEF00D, 32'h13579BDF);
        wait_resp(5, 1'b0);
        chk("bp_x", got_x, 32'hCAFEF00D);
        chk("bp_y", got_y, 32'h13579BDF);
        chk("bp_ready_after_hs", bus.cmd_ready, 1'b1);
        chk("bp_valid_after_hs", bus.rsp_valid, 1'b0);

        // Spurious done during SEND at cnt=3
        start_cnt = 0; px_cnt = 0;
        send_cmd(32'h11111111, 32'h22222222, 32'h87654321, 32'h33333333, 32'h44444444, 1'b0);
        repeat (3) @(negedge clk);
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
        do_core(4, 32'hA5A5A5A5, 32'h5A5A5A5A);
        wait_resp(0, 1'b0);
        chk("spur_px_nibbles", px_cnt, 8);
        chk("spur_start_pulses", start_cnt, 1);
        chk("spur_x", got_x, 32'hA5A5A5A5);
        chk("spur_y", got_y, 32'h5A5A5A5A);

        // Back-to-back
        bus.rsp_ready = 1'b1;
        send_cmd(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314, 1'b1);
        bus.cmd_a = 32'hF0E0D0C0; bus.cmd_prime = 32'hB0A09080; bus.cmd_px = 32'h70605040;
        bus.cmd_py = 32'h30201000; bus.cmd_k = 32'h0000FFFF;
        do_core(8, 32'h11223344, 32'h55667788);
        wait_resp(0, 1'b1);
        chk("b2b_x1", got_x, 32'h11223344);
        chk("b2b_y1", got_y, 32'h55667788);
        hs1 = hs_cyc;
        n = 0;
        while (!o_start && n < 50) begin @(negedge clk); n++; end
        chk("b2b_second_start", o_start, 1'b1);
        bus.cmd_valid = 1'b0;
        do_core(8, 32'h99AABBCC, 32'hDDEEFF00);
        wait_resp(0, 1'b0);
        chk("b2b_gap", acc_cyc - hs1, 1);
        chk("b2b_x2", got_x, 32'h99AABBCC);
        chk("b2b_y2", got_y, 32'hDDEEFF00);

        // No done from the core
        rv_cnt = 0;
        send_cmd(32'h7, 32'h17, 32'h3, 32'h9, 32'h5, 1'b0);
`ifdef ECC_HOST_TIMEOUT_EN
        wait_resp(0, 1'b0);
        chk("to_latency", rise_cyc - acc_cyc, NIB + TO);
        chk("to_flag", got_to, 1'b1);
        chk("to_x", got_x, 32'h0);
        chk("to_y", got_y, 32'h0);
`else
        repeat (1000) @(negedge clk);
        chk("no_rsp_without_done", rv_cnt, 0);
`endif

        // Reset mid-SEND at cnt=4
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rv_cnt = 0;
        send_cmd(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_link", {o_start, o_a, o_prime, o_px, o_py, o_k}, 21'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", bus.cmd_ready, 1'b1);
        chk("rst_no_rsp", rv_cnt, 0);
        send_cmd(32'h2, 32'h11, 32'h5, 32'h1, 32'h2, 1'b0);
        do_core(9, 32'h0BADC0DE, 32'h600DF00D);
        wait_resp(0, 1'b0);
        chk("rst_next_x", got_x, 32'h0BADC0DE);
        chk("rst_next_y", got_y, 32'h600DF00D);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ecc_serial_host.md
# ecc_serial_host

Host-side endpoint of the ECC core's nibble-serial link. It accepts one scalar-multiplication command with parallel operands a, prime, Px, Py and k over a valid/ready handshake. It shifts the operands out to the core as 4-bit nibbles framed by a start pulse, waits for the core's done, then reassembles the nibble-serial kPx/kPy result into parallel words on a response handshake. It sits between the system bus adapter and the ECC core.

## Interface
- NIBBLES, 8: nibbles per operand/result; W = 4*NIBBLES (32 by default).
- TIMEOUT, 4096: maximum WAIT cycles before a timeout response; only used with ECC_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a, cmd_prime, cmd_px, cmd_py, cmd_k  in  W each  parallel operands.
- o_start  out  1  one-cycle frame start to the core, coincident with nibble 0.
- o_a, o_prime, o_px, o_py, o_k  out  4 each  operand nibbles to the core.
- i_done  in  1  core completion pulse.
- i_kpx, i_kpy  in  4 each  result nibbles from the core.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_x, rsp_y  out  W each  assembled kPx and kPy.
- rsp_timeout  out  1  response is a timeout, not a result.

## Operation
- States: IDLE, SEND, WAIT, RECV, RESP. Nibble counter cnt runs 0..NIBBLES-1.
- IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all five operands, clear rsp_x/rsp_y/rsp_timeout, set cnt=0, and go to SEND.
- SEND: cmd_ready=0.
  - Each cycle drive nibble cnt (bits 4*cnt+3:4*cnt, LSB nibble first) of each latched operand. o_start=1 only when cnt==0.
  - After cnt==NIBBLES-1, go to WAIT.
  - i_done is ignored in SEND.
- WAIT:
  - o_* are 0. The wait counter clears on entry.
  - When i_done is sampled high, set cnt=0 and go to RECV.
- RECV:
  - Every cycle, capture i_kpx into rsp_x[4*cnt+:4] and i_kpy into rsp_y[4*cnt+:4].
  - After capturing cnt==NIBBLES-1, go to RESP.
  - i_done during RECV is ignored.
- RESP:
  - rsp_valid=1. rsp_* are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, return to IDLE.
- Outside SEND, o_start and all o_* nibbles are 0.
- Reset, including mid-operation: return to IDLE and abort with no response emitted. All outputs 0; rsp_timeout=0.

## Timing
- Reset values: cmd_ready=0 while reset is asserted, then 1 in the first cycle after reset deasserts. All other outputs are 0.
- Command accepted at edge T:
  - o_start and nibble 0 are valid in cycle T..T+1.
  - Nibble 7 is valid in cycle T+7..T+8.
  - WAIT is entered at edge T+8.
- i_done sampled high at edge D:
  - Nibble 0 is captured at edge D+1 and nibble 7 at edge D+8.
  - rsp_valid rises after edge D+8.
- Response accepted at edge R: cmd_ready=1 from edge R onward. A new command can be accepted at edge R+1 at the earliest.
- Minimum command-to-command period is 2*NIBBLES+2 cycles plus core latency.

## Configuration
- ECC_HOST_TIMEOUT_EN defined:
  - WAIT counts cycles.
  - When TIMEOUT cycles have elapsed without i_done, go to RESP with rsp_timeout=1 and rsp_x=rsp_y=0.
  - An i_done arriving in the same cycle the count expires wins, and RECV proceeds normally.
- Not defined: no counter is instantiated, WAIT is unbounded, and rsp_timeout is tied to 0.

## Test plan
- Basic transfer: cmd_a=0x00000002, cmd_prime=0x00000011, cmd_px=0x00000005, cmd_py=0x00000001, cmd_k=0x00000002.
  - Required: o_start for exactly 1 cycle; o_prime sequence 1,1,0,0,0,0,0,0.
  - Core model then pulses done and returns i_kpx nibbles 8,7,6,5,4,3,2,1 and i_kpy nibbles F,E,D,C,B,A,9,0 -> rsp_x=0x12345678, rsp_y=0x09ABCDEF, rsp_timeout=0.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_x/rsp_y stable, cmd_ready=0; rsp_ready=1 -> IDLE next cycle.
- Spurious done: pulse i_done during SEND cnt=3 -> ignored, still exactly 8 nibbles sent; a later valid done completes normally.
- Timeout (ECC_HOST_TIMEOUT_EN, TIMEOUT=16): never assert i_done -> rsp_valid with rsp_timeout=1 and rsp_x=rsp_y=0 after 16 WAIT cycles.
  - Repeat without the macro -> no response after 1000 cycles.
- Reset mid-SEND at cnt=4 -> o_start and all o_* 0, no rsp_valid. cmd_ready=1 the cycle after reset deasserts, and the next command transfers correctly.
- Back-to-back: cmd_valid held high with rsp_ready=1 -> second command accepted exactly one cycle after the first response handshake, and both results are correct.
